// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared definitions for the single-clock FIFO controller family:
//   FIFO_MODE_STD / FIFO_MODE_FWFT  values of the FWFT parameter
//   lvl_w()                         width of pointers / level counter
package fifo_ctrl_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // One extra bit over the RAM address so that level = 2^depth_width fits
   // and pointers carry a wrap bit.
   function automatic int lvl_w(input int depth_width);
      return depth_width + 1;
   endfunction

endpackage

// File: rtl/fifo_fwft_outbuf.sv
// fifo_fwft_outbuf
// First-word-fall-through output pipeline: S0 presents the head word, S1 is a
// skid slot absorbing a RAM read that was launched before a pop stalled.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   avail_i       RAM holds words not yet fetched
//   rd_en_i       consumer pop request
//   ram_rdata_i   RAM read data (valid the cycle after fetch_o)
//   fetch_o       launch a RAM read this cycle
//   pop_o         accepted pop (rd_en_i while S0 valid)
//   s0_v_o        head word valid (FIFO not empty)
//   rd_data_o     head word
module fifo_fwft_outbuf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  avail_i,
   input  logic                  rd_en_i,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic                  fetch_o,
   output logic                  pop_o,
   output logic                  s0_v_o,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic                  s0_v_q, s0_v_d, s1_v_q, s1_v_d, pend_q;
   logic [DATA_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
   logic [1:0]            occ;

   assign pop_o = rd_en_i & s0_v_q;

   // Slots still committed after this cycle's pop; a pop implies s0_v so the
   // subtraction cannot go negative. Fetch only if a slot stays free, which
   // guarantees arriving data always finds S0 or S1 empty.
   assign occ     = {1'b0, s0_v_q} + {1'b0, s1_v_q} + {1'b0, pend_q} - {1'b0, pop_o};
   assign fetch_o = avail_i & (occ < 2'd2);

   always_comb begin
      s0_v_d = s0_v_q;
      s0_d   = s0_q;
      s1_v_d = s1_v_q;
      s1_d   = s1_q;
      if (pop_o) begin
         s0_v_d = s1_v_q;
         s0_d   = s1_v_q ? s1_q : s0_q;
         s1_v_d = 1'b0;
      end
      if (pend_q) begin
         if (!s0_v_d) begin
            s0_v_d = 1'b1;
            s0_d   = ram_rdata_i;
         end else begin
            s1_v_d = 1'b1;
            s1_d   = ram_rdata_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v_q <= 1'b0;
         s1_v_q <= 1'b0;
         pend_q <= 1'b0;
         s0_q   <= '0;
         s1_q   <= '0;
      end else begin
         s0_v_q <= s0_v_d;
         s1_v_q <= s1_v_d;
         pend_q <= fetch_o;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
      end
   end

   assign s0_v_o    = s0_v_q;
   assign rd_data_o = s0_q;

endmodule

// File: rtl/sync_fifo_ctrl_fwft.sv
// sync_fifo_ctrl_fwft
// Single-clock FIFO controller driving an external simple-dual-port RAM with
// 1-cycle read latency. Standard (FWFT=0) or first-word-fall-through (FWFT=1).
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   wr_en, wr_data, full            write side
//   rd_en, rd_data, empty           read side
//   almost_full/_empty, *_thresh    programmable level flags
//   water_level                     total words held (incl. FWFT pipeline)
//   overflow, underflow, clr_err    sticky error flags and their clear
//   ram_*                           external RAM interface
module sync_fifo_ctrl_fwft
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WIDTH = 9,
   parameter int FWFT        = FIFO_MODE_STD
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [DEPTH_WIDTH:0]   water_level,
   input  logic [DEPTH_WIDTH:0]   af_thresh,
   input  logic [DEPTH_WIDTH:0]   ae_thresh,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_err,
   output logic                   ram_we,
   output logic [DEPTH_WIDTH-1:0] ram_waddr,
   output logic [DATA_WIDTH-1:0]  ram_wdata,
   output logic                   ram_re,
   output logic [DEPTH_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0]  ram_rdata
);

   localparam int            LW    = lvl_w(DEPTH_WIDTH);
   localparam logic [LW-1:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};

   logic [LW-1:0] wptr_q, rptr_q, lvl_q, lvl_d;
   logic          full_q, af_q, ae_q, ov_q, un_q;
   logic          wa, ra, rd_empty, rd_fetch;

   // Full is checked alone: a write at full is dropped even when a read frees
   // a slot in the same cycle.
   assign wa = wr_en & ~full_q;

   always_comb begin
      lvl_d = lvl_q;
      if (wa & ~ra)      lvl_d = lvl_q + 1'b1;
      else if (ra & ~wa) lvl_d = lvl_q - 1'b1;
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      logic [LW-1:0] ram_count;
      logic          s0_v;
      assign ram_count = wptr_q - rptr_q;
      fifo_fwft_outbuf #(.DATA_WIDTH(DATA_WIDTH)) u_outbuf (
         .clk        (clk),
         .rst_n      (rst_n),
         .avail_i    (ram_count != '0),
         .rd_en_i    (rd_en),
         .ram_rdata_i(ram_rdata),
         .fetch_o    (rd_fetch),
         .pop_o      (ra),
         .s0_v_o     (s0_v),
         .rd_data_o  (rd_data)
      );
      assign rd_empty = ~s0_v;
   end else begin : g_std
      logic                  empty_q, rvld_q;
      logic [DATA_WIDTH-1:0] hold_q;
      assign ra       = rd_en & ~empty_q;
      assign rd_fetch = ra;
      assign rd_empty = empty_q;
      // RAM output is passed through the cycle after a read; otherwise the
      // last word is held so rd_data stays stable (and 0 out of reset).
      assign rd_data  = rvld_q ? ram_rdata : hold_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            empty_q <= 1'b1;
            rvld_q  <= 1'b0;
            hold_q  <= '0;
         end else begin
            empty_q <= (lvl_d == '0);
            rvld_q  <= ra;
            if (rvld_q) hold_q <= ram_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         lvl_q  <= '0;
         full_q <= 1'b0;
         af_q   <= 1'b0;
         ae_q   <= 1'b1;
         ov_q   <= 1'b0;
         un_q   <= 1'b0;
      end else begin
         if (wa)       wptr_q <= wptr_q + 1'b1;
         if (rd_fetch) rptr_q <= rptr_q + 1'b1;
         lvl_q  <= lvl_d;
         full_q <= (lvl_d == DEPTH);
         af_q   <= (lvl_d >= af_thresh);
         ae_q   <= (lvl_d <= ae_thresh);
         // New error wins over a simultaneous clear.
         ov_q   <= (wr_en & full_q)   | (ov_q & ~clr_err);
         un_q   <= (rd_en & rd_empty) | (un_q & ~clr_err);
      end
   end

   assign full         = full_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign empty        = rd_empty;
   assign water_level  = lvl_q;
   assign overflow     = ov_q;
   assign underflow    = un_q;
   assign ram_we       = wa;
   assign ram_waddr    = wptr_q[DEPTH_WIDTH-1:0];
   assign ram_wdata    = wr_data;
   assign ram_re       = rd_fetch;
   assign ram_raddr    = rptr_q[DEPTH_WIDTH-1:0];

endmodule

// File: tb/tb_sync_fifo_ctrl_fwft.sv
// tb_sync_fifo_ctrl_fwft
// Bench for sync_fifo_ctrl_fwft: one standard-mode and one FWFT-mode instance,
// each with its own behavioural RAM, checked against a level model and a data
// scoreboard queue.
module tb_sync_fifo_ctrl_fwft;
   localparam int DW    = 4;
   localparam int W     = 32;
   localparam int DEPTH = 16;

   logic clk = 1'b0, rst_n = 1'b1, clr_err = 1'b0;
   logic [DW:0] af_th = 5'd12, ae_th = 5'd3;
   always #5 clk = ~clk;

   logic          s_wr_en = 0, s_rd_en = 0, s_full, s_af, s_empty, s_ae, s_ov, s_un, s_ram_we, s_ram_re;
   logic [W-1:0]  s_wr_data = '0, s_rd_data, s_ram_wdata, s_ram_rdata;
   logic [DW:0]   s_wl;
   logic [DW-1:0] s_ram_waddr, s_ram_raddr;
   logic [W-1:0]  s_mem [DEPTH];

   logic          f_wr_en = 0, f_rd_en = 0, f_full, f_af, f_empty, f_ae, f_ov, f_un, f_ram_we, f_ram_re;
   logic [W-1:0]  f_wr_data = '0, f_rd_data, f_ram_wdata, f_ram_rdata;
   logic [DW:0]   f_wl;
   logic [DW-1:0] f_ram_waddr, f_ram_raddr;
   logic [W-1:0]  f_mem [DEPTH];

   sync_fifo_ctrl_fwft #(.DATA_WIDTH(W), .DEPTH_WIDTH(DW), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full),
      .almost_full(s_af), .rd_en(s_rd_en), .rd_data(s_rd_data), .empty(s_empty),
      .almost_empty(s_ae), .water_level(s_wl), .af_thresh(af_th), .ae_thresh(ae_th),
      .overflow(s_ov), .underflow(s_un), .clr_err(clr_err), .ram_we(s_ram_we),
      .ram_waddr(s_ram_waddr), .ram_wdata(s_ram_wdata), .ram_re(s_ram_re),
      .ram_raddr(s_ram_raddr), .ram_rdata(s_ram_rdata));

   sync_fifo_ctrl_fwft #(.DATA_WIDTH(W), .DEPTH_WIDTH(DW), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full),
      .almost_full(f_af), .rd_en(f_rd_en), .rd_data(f_rd_data), .empty(f_empty),
      .almost_empty(f_ae), .water_level(f_wl), .af_thresh(af_th), .ae_thresh(ae_th),
      .overflow(f_ov), .underflow(f_un), .clr_err(clr_err), .ram_we(f_ram_we),
      .ram_waddr(f_ram_waddr), .ram_wdata(f_ram_wdata), .ram_re(f_ram_re),
      .ram_raddr(f_ram_raddr), .ram_rdata(f_ram_rdata));

   always @(posedge clk) begin
      if (s_ram_we) s_mem[s_ram_waddr] <= s_ram_wdata;
      if (s_ram_re) s_ram_rdata <= s_mem[s_ram_raddr];
      if (f_ram_we) f_mem[f_ram_waddr] <= f_ram_wdata;
      if (f_ram_re) f_ram_rdata <= f_mem[f_ram_raddr];
   end

   int n_chk = 0, n_pass = 0;
   int s_lvl = 0, f_lvl = 0;
   bit s_ovm, s_unm, f_ovm, f_unm;
   logic [W-1:0] sq[$], fq[$];

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic s_tick(input bit wr, input logic [W-1:0] d, input bit rd);
      bit wa, ra;
      logic [W-1:0] e;
      s_wr_en = wr; s_wr_data = d; s_rd_en = rd;
      wa = wr && s_lvl != DEPTH;
      ra = rd && s_lvl != 0;
      s_ovm = (wr && s_lvl == DEPTH) || (s_ovm && !clr_err);
      s_unm = (rd && s_lvl == 0) || (s_unm && !clr_err);
      e = '0;
      if (ra) e = sq.pop_front();
      if (wa) sq.push_back(d);
      @(posedge clk); #1;
      s_wr_en = 0; s_rd_en = 0;
      s_lvl += int'(wa) - int'(ra);
      chk("s_level", s_wl, s_lvl);
      chk("s_full", s_full, s_lvl == DEPTH);
      chk("s_empty", s_empty, s_lvl == 0);
      chk("s_afull", s_af, s_lvl >= int'(af_th));
      chk("s_aempty", s_ae, s_lvl <= int'(ae_th));
      chk("s_overflow", s_ov, s_ovm);
      chk("s_underflow", s_un, s_unm);
      if (ra) chk("s_rd_data", s_rd_data, e);
   endtask

   task automatic f_tick(input bit wr, input logic [W-1:0] d, input bit rd, output bit pop);
      bit wa;
      f_wr_en = wr; f_wr_data = d; f_rd_en = rd;
      wa  = wr && f_lvl != DEPTH;
      pop = rd && !f_empty;
      f_ovm = (wr && f_lvl == DEPTH) || (f_ovm && !clr_err);
      f_unm = (rd && f_empty) || (f_unm && !clr_err);
      if (pop) begin
         chk("f_q_nonempty", fq.size() != 0, 1);
         if (fq.size() != 0) chk("f_rd_data", f_rd_data, fq.pop_front());
      end
      if (wa) fq.push_back(d);
      @(posedge clk); #1;
      f_wr_en = 0; f_rd_en = 0;
      f_lvl += int'(wa) - int'(pop);
      chk("f_level", f_wl, f_lvl);
      chk("f_full", f_full, f_lvl == DEPTH);
      chk("f_afull", f_af, f_lvl >= int'(af_th));
      chk("f_aempty", f_ae, f_lvl <= int'(ae_th));
      chk("f_overflow", f_ov, f_ovm);
      chk("f_underflow", f_un, f_unm);
      if (f_lvl == 0) chk("f_empty_at_0", f_empty, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_s_empty", s_empty, 1);  chk("rst_f_empty", f_empty, 1);
      chk("rst_s_level", s_wl, 0);     chk("rst_f_level", f_wl, 0);
      chk("rst_s_full", s_full, 0);    chk("rst_f_full", f_full, 0);
      chk("rst_s_afull", s_af, 0);     chk("rst_f_aempty", f_ae, 1);
      chk("rst_s_ovf", s_ov, 0);       chk("rst_f_unf", f_un, 0);
      chk("rst_s_rdata", s_rd_data, 0); chk("rst_f_rdata", f_rd_data, 0);
      sq.delete(); fq.delete();
      s_lvl = 0; f_lvl = 0;
      s_ovm = 0; s_unm = 0; f_ovm = 0; f_unm = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit p;
      int first, last, npop;
      #1;
      do_reset();

      // ---- standard mode ----
      s_tick(1, 32'hA1, 0); s_tick(1, 32'hA2, 0);
      s_tick(0, 0, 1);      s_tick(0, 0, 1);
      s_tick(0, 0, 1);                                   // underflow
      clr_err = 1; s_tick(0, 0, 0); clr_err = 0;
      for (int i = 0; i < DEPTH; i++) s_tick(1, 32'h100 + i, 0);
      s_tick(1, 32'hDEAD, 0);                            // dropped, overflow
      clr_err = 1; s_tick(0, 0, 0); clr_err = 0;
      s_tick(1, 32'hBEEF, 1);                            // at full: write rejected
      clr_err = 1; s_tick(1, 32'h111, 0); clr_err = 0;   // back to full
      s_tick(1, 32'h222, 0);                             // overflow again
      clr_err = 1; s_tick(0, 0, 0); clr_err = 0;
      for (int i = 0; i < 13; i++) s_tick(0, 0, 1);      // drain to 3
      for (int i = 0; i < 9; i++) s_tick(1, 32'h400 + i, 0);  // fill to 12
      s_tick(0, 0, 1);                                   // 11
      af_th = 5'd10;
      s_tick(0, 0, 0);                                   // afull via new threshold
      af_th = 5'd12;
      for (int i = 0; i < 11; i++) s_tick(0, 0, 1);
      for (int i = 0; i < 100; i++) s_tick(1, 32'h1000 + i, 1);
      for (int i = 0; i < 4; i++) s_tick(1, 32'h2000 + i, i[0]);
      do_reset();
      s_tick(0, 0, 0);
      s_tick(1, 32'h77, 0); s_tick(0, 0, 1);

      // ---- FWFT mode ----
      do_reset();
      f_tick(1, 32'h55, 0, p);
      chk("f_lat_c1_empty", f_empty, 1);
      f_tick(0, 0, 0, p);
      chk("f_lat_c2_empty", f_empty, 1);
      f_tick(0, 0, 0, p);
      chk("f_lat_c3_empty", f_empty, 0);
      chk("f_lat_c3_data", f_rd_data, 32'h55);
      f_tick(0, 0, 1, p);
      first = -1; last = -1; npop = 0;
      for (int c = 0; c < 40; c++) begin
         f_tick(c < 32, 32'h200 + c, 1, p);
         if (p) begin
            if (first < 0) first = c;
            last = c; npop++;
         end
      end
      chk("f_stream_pops", npop, 32);
      chk("f_stream_span", last - first, 31);
      clr_err = 1; f_tick(0, 0, 0, p); clr_err = 0;
      for (int i = 0; i < DEPTH; i++) f_tick(1, 32'h500 + i, 0, p);
      f_tick(1, 32'hDEAD, 0, p);                          // overflow
      for (int i = 0; i < 40 && f_lvl > 0; i++) f_tick(0, 0, 1, p);
      chk("f_drained1", fq.size(), 0);
      for (int i = 0; i < 100; i++) f_tick(1, 32'h3000 + i, 1, p);
      for (int i = 0; i < 40 && f_lvl > 0; i++) f_tick(0, 0, 1, p);
      chk("f_drained2", fq.size(), 0);
      for (int i = 0; i < 6; i++) f_tick(1, 32'h600 + i, i > 2, p);
      do_reset();                                         // reads in flight
      for (int i = 0; i < 4; i++) f_tick(0, 0, 0, p);
      f_tick(1, 32'h77, 0, p);
      for (int i = 0; i < 8 && f_empty; i++) f_tick(0, 0, 0, p);
      chk("f_post_rst_vis", f_empty, 0);
      chk("f_post_rst_data", f_rd_data, 32'h77);
      f_tick(0, 0, 1, p);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sync_fifo_ctrl_fwft.md
Name: sync_fifo_ctrl_fwft

Overview:
Single-clock FIFO controller, next generation of the Pango IP FIFO controller family. Drives an external simple-dual-port RAM (1-cycle read latency) and owns the read data path. Adds over the previous generation: selectable standard / first-word-fall-through (FWFT) read mode, runtime-programmable almost thresholds, a single occupancy counter, and sticky overflow/underflow flags. Used in the AXI4 slave address/data buffering paths where both sides share one clock.

Parameters:
DATA_WIDTH, 32, data word width
DEPTH_WIDTH, 9, log2 of RAM depth; depth = 2^DEPTH_WIDTH
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through mode

Ports:
clk  in  1  single clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  FIFO full (registered)
almost_full  out  1  level >= af_thresh (registered)
rd_en  in  1  read request (FWFT: pop/acknowledge)
rd_data  out  DATA_WIDTH  read data
empty  out  1  no readable data (registered)
almost_empty  out  1  level <= ae_thresh (registered)
water_level  out  DEPTH_WIDTH+1  total entries held, 0..2^DEPTH_WIDTH
af_thresh  in  DEPTH_WIDTH+1  almost-full threshold, sampled every cycle
ae_thresh  in  DEPTH_WIDTH+1  almost-empty threshold, sampled every cycle
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow
ram_we  out  1  RAM write enable
ram_waddr  out  DEPTH_WIDTH  RAM write address
ram_wdata  out  DATA_WIDTH  RAM write data (= wr_data)
ram_re  out  1  RAM read enable
ram_raddr  out  DEPTH_WIDTH  RAM read address
ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re

Behaviour:
- Reset (rst_n low, asynchronous): pointers, counters, pipeline valids = 0; full=0, almost_full=0, empty=1, almost_empty=1, water_level=0, overflow=0, underflow=0, rd_data=0. Reset mid-operation discards all contents and in-flight RAM reads.
- Pointers are binary, DEPTH_WIDTH+1 bits; the MSB is the wrap bit. RAM address = the low DEPTH_WIDTH bits. Wrap from 2^(DEPTH_WIDTH+1)-1 to 0 is natural.
- Write accept: wa = wr_en & !full. On wa: ram_we=1 combinationally, ram_waddr=wptr, and wptr increments.
- wr_en & full: write dropped, overflow set.
- ram_count = wptr - rptr_ram (entries not yet fetched from RAM).
- water_level = entries held, including the FWFT pipeline. It is a register updated by +wa -ra, saturating at neither end; correct control guarantees the range 0..2^DEPTH_WIDTH.
- full = (next water_level == 2^DEPTH_WIDTH).
- almost_full = (next level >= af_thresh).
- almost_empty = (next level <= ae_thresh).
- Simultaneous wa and ra: level unchanged.
- A write while full is rejected even if a read occurs in the same cycle.
- Standard mode (FWFT=0):
  - ra = rd_en & !empty; ram_re=ra, ram_raddr=rptr_ram.
  - rd_data = ram_rdata, valid the cycle after ra (latency 1).
  - empty = (next level == 0). First write to an empty FIFO deasserts empty the next cycle.
  - rd_en & empty: read dropped, underflow set.
- FWFT mode (FWFT=1):
  - Two-slot output pipeline: S0 (drives rd_data, valid s0_v) and S1 (skid, valid s1_v), plus a pend flag marking a RAM read in flight.
  - empty = !s0_v; ra = rd_en & s0_v (pop of S0).
  - Prefetch: ram_re = (ram_count>0) & ((s0_v + s1_v + pend - ra) < 2).
  - RAM data arriving (pend) goes to S0 if S0 is empty after the pop, else to S1. On a pop with s1_v, S1 moves to S0.
  - Sustains one read per cycle.
  - Write to an empty FIFO: empty deasserts 3 cycles after the write cycle, with rd_data = that word.
  - rd_en with empty: underflow set, no state change.
- Sticky flags:
  - overflow and underflow hold until clr_err.
  - If clr_err and a new error occur in the same cycle, the flag stays 1 (set wins).

Decomposition:
- Shared package fifo_ctrl_pkg: mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1) and a function returning the level width (DEPTH_WIDTH+1).
- One sub-module, fifo_fwft_outbuf: the S0/S1/pend pipeline. Instantiated only when FWFT=1 (generate); the standard mode bypasses it.

Test Plan:
- Reset/basic, DEPTH_WIDTH=4, FWFT=0: write 0xA1 then 0xA2; read twice -> rd_data 0xA1 and 0xA2 one cycle after each rd_en; empty=1 after the 2nd read; water_level 2->0.
- Fill/overflow, DEPTH_WIDTH=4: 16 writes -> full=1 and water_level=16. 17th write dropped and overflow=1; pulse clr_err -> overflow=0.
- Simultaneous at full: wr_en & rd_en while full -> write rejected, overflow=1, water_level=15 next cycle.
- FWFT latency/throughput: write 0x55 to an empty FIFO -> empty low 3 cycles later with rd_data=0x55. Then write 32 words while reading continuously -> the data sequence is intact with no bubbles once primed.
- Thresholds: af_thresh=12, ae_thresh=3; fill to 12 -> almost_full=1 at level 12 only; drain to 3 -> almost_empty=1. Change af_thresh to 10 at level 11 -> almost_full=1 next cycle.
- Pointer wrap and reset: 100 write/read pairs through the 16-deep FIFO -> data order preserved. Assert rst_n low mid-burst -> empty=1, water_level=0, and stale RAM data is never presented.
